star_max_sub: RTL

//  Downstream consumer of the STAR row fetch: accepts one 16-byte row as a valid/ready

---
 rtl/star_max_sub_if.sv | 35 +++
 rtl/star_max_sub.sv | 118 +++++++++++
 2 files changed

// File: rtl/star_max_sub_if.sv
// ----------------------------------------------------------------------------
// star_max_sub_if
// Stream bundle between the STAR row fetch and the max-subtract stage.
//   in_valid / in_data / in_ready                : row element stream into the block
//   out_valid / out_data / out_idx / out_last /
//   out_ready                                    : max-subtracted element stream out
// Modports:
//   slave  : the max-subtract block (consumes rows, produces results)
//   master : the environment around it (produces rows, consumes results)
// ----------------------------------------------------------------------------
interface star_max_sub_if #(
   parameter int DATA_W = 8,
   parameter int N      = 16
);
   localparam int IDX_W = $clog2(N);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/star_max_sub.sv
// ----------------------------------------------------------------------------
// star_max_sub
// Buffers one N-element row, tracks its unsigned maximum while loading, then
// streams (max - x[i]) in arrival order ahead of the exponent stage.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of star_max_sub_if (input row stream, output stream)
//   max_val  : row maximum, stable from the first output until the next row starts
//   done     : one-cycle pulse after the last output element is accepted
// ----------------------------------------------------------------------------
module star_max_sub #(
   parameter int DATA_W = 8,
   parameter int N      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   star_max_sub_if.slave     bus,
   output logic [DATA_W-1:0] max_val,
   output logic              done
);
   localparam int               IDX_W    = $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  wcnt;
   logic [DATA_W-1:0] row_buf [N];

   logic              take_in;
   logic              take_out;
   logic [IDX_W-1:0]  idx_nxt;
   logic [DATA_W-1:0] run_max;

   function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (a >= b) ? a : b;
   endfunction

   // The running max dominates every buffered element, so this never wraps.
   function automatic logic [DATA_W-1:0] sub_from_max(input logic [DATA_W-1:0] mx,
                                                      input logic [DATA_W-1:0] x);
      return mx - x;
   endfunction

   always_comb begin
      take_in  = bus.in_valid & bus.in_ready;
      take_out = bus.out_valid & bus.out_ready;
      idx_nxt  = bus.out_idx + IDX_W'(1);
      // First element of a row replaces the previous row's max outright.
      run_max  = (wcnt == '0) ? bus.in_data : umax(max_val, bus.in_data);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= LOAD;
         wcnt         <= '0;
         for (int i = 0; i < N; i++) row_buf[i] <= '0;
         max_val      <= '0;
         done         <= 1'b0;
         bus.in_ready <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_idx  <= '0;
         bus.out_last <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            LOAD: begin
               // in_ready rises on the first clock after reset release.
               bus.in_ready <= 1'b1;
               if (take_in) begin
                  row_buf[wcnt] <= bus.in_data;
                  max_val       <= run_max;
                  wcnt          <= wcnt + IDX_W'(1);
                  if (wcnt == LAST_IDX) begin
                     // Element 0 was buffered earlier (N >= 2), so the first
                     // result can be presented on the very next cycle.
                     state         <= EMIT;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                     bus.out_idx   <= '0;
                     bus.out_last  <= 1'b0;
                     bus.out_data  <= sub_from_max(run_max, row_buf[0]);
                  end
               end
            end
            EMIT: begin
               if (take_out) begin
                  if (bus.out_last) begin
                     state         <= DONE;
                     bus.out_valid <= 1'b0;
                     bus.out_last  <= 1'b0;
                     done          <= 1'b1;
                  end else begin
                     bus.out_idx  <= idx_nxt;
                     bus.out_data <= sub_from_max(max_val, row_buf[idx_nxt]);
                     bus.out_last <= (idx_nxt == LAST_IDX);
                  end
               end
            end
            DONE: begin
               state        <= LOAD;
               bus.in_ready <= 1'b1;
            end
            default: begin
               state        <= LOAD;
               bus.in_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule
